// File: rtl/alu_dispatch_pkg.sv
// Shared definitions for the ALU issue controller and the ALU itself:
// opcode map, flag bit positions and dispatcher state encodings.
package alu_dispatch_pkg;

    localparam logic [5:0] OP_ADD = 6'h00;
    localparam logic [5:0] OP_SUB = 6'h01;
    localparam logic [5:0] OP_MUL = 6'h02;
    localparam logic [5:0] OP_DIV = 6'h03;
    localparam logic [5:0] OP_MOD = 6'h04;
    localparam logic [5:0] OP_AND = 6'h05;
    localparam logic [5:0] OP_OR  = 6'h06;
    localparam logic [5:0] OP_XOR = 6'h07;
    localparam logic [5:0] OP_NOT = 6'h08;
    localparam logic [5:0] OP_CMP = 6'h09;
    localparam logic [5:0] OP_LSL = 6'h0A;
    localparam logic [5:0] OP_RSR = 6'h0B;
    localparam logic [5:0] OP_LAST = OP_RSR;

    // Bit positions inside the {V,C,N,Z} flag register
    localparam int FL_Z = 0;
    localparam int FL_N = 1;
    localparam int FL_C = 2;
    localparam int FL_V = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_timeout_ctr.sv
// 8-bit BUSY-cycle counter; expired_o flags the last permitted cycle so the
// dispatcher leaves BUSY exactly TIMEOUT cycles after entering it.
module alu_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: clear wins over enable
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/alu_dispatch.sv
// Issue controller in front of the 16-bit ALU: accepts one operation per
// handshake, waits for done under a timeout, and returns a registered response.
module alu_dispatch
    import alu_dispatch_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int OP_W    = 6,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_opcode,
    input  logic [DATA_W-1:0] in_term1,
    input  logic [DATA_W-1:0] in_term2,
    output logic              alu_enable,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [DATA_W-1:0] alu_term1,
    output logic [DATA_W-1:0] alu_term2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_fl_zero,
    input  logic              alu_fl_negative,
    input  logic              alu_fl_carry,
    input  logic              alu_fl_overflow,
    input  logic              alu_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_wb,
    output logic              out_error,
    output logic [3:0]        flags
);

    logic [1:0]        state_q,  state_d;
    logic [OP_W-1:0]   opcode_q, opcode_d;
    logic [DATA_W-1:0] term1_q,  term1_d;
    logic [DATA_W-1:0] term2_q,  term2_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              wb_q,     wb_d;
    logic              error_q,  error_d;
    logic [3:0]        flags_q,  flags_d;
    logic              accept_s;
    logic              reject_s;
    logic              expired_s;

    assign accept_s = (state_q == ST_IDLE) && in_valid;
    // Illegal opcodes and zero divisors never reach the ALU
    assign reject_s = (in_opcode > OP_W'(OP_LAST)) ||
                      (((in_opcode == OP_W'(OP_DIV)) || (in_opcode == OP_W'(OP_MOD))) &&
                       (in_term2 == {DATA_W{1'b0}}));

    alu_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk       (clk),
        .rst_b     (rst_b),
        .clr_i     (accept_s),
        .en_i      (state_q == ST_BUSY),
        .expired_o (expired_s)
    );

    // Next-state and response logic
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        term1_d  = term1_q;
        term2_d  = term2_q;
        result_d = result_q;
        wb_d     = wb_q;
        error_d  = error_q;
        flags_d  = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    opcode_d = in_opcode;
                    term1_d  = in_term1;
                    term2_d  = in_term2;
                    if (reject_s) begin
                        result_d = {DATA_W{1'b0}};
                        wb_d     = 1'b0;
                        error_d  = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        state_d  = ST_BUSY;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // done in the last counted cycle beats the timeout
                if (alu_done) begin
                    result_d       = alu_result;
                    flags_d[FL_Z]  = alu_fl_zero;
                    flags_d[FL_N]  = alu_fl_negative;
                    flags_d[FL_C]  = alu_fl_carry;
                    flags_d[FL_V]  = alu_fl_overflow;
                    error_d        = 1'b0;
                    wb_d           = (opcode_q != OP_W'(OP_CMP));
                    state_d        = ST_RESP;
                end else if (expired_s) begin
                    result_d = {DATA_W{1'b0}};
                    wb_d     = 1'b0;
                    error_d  = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= ST_IDLE;
            opcode_q <= {OP_W{1'b0}};
            term1_q  <= {DATA_W{1'b0}};
            term2_q  <= {DATA_W{1'b0}};
            result_q <= {DATA_W{1'b0}};
            wb_q     <= 1'b0;
            error_q  <= 1'b0;
            flags_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            term1_q  <= term1_d;
            term2_q  <= term2_d;
            result_q <= result_d;
            wb_q     <= wb_d;
            error_q  <= error_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign alu_enable = (state_q == ST_BUSY);
    assign out_valid  = (state_q == ST_RESP);
    assign alu_opcode = opcode_q;
    assign alu_term1  = term1_q;
    assign alu_term2  = term2_q;
    assign out_result = result_q;
    assign out_wb     = wb_q;
    assign out_error  = error_q;
    assign flags      = flags_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a small behavioural ALU whose done
// timing is programmable per test.
module tb_alu_dispatch;

    logic        clk;
    logic        rst_b;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_opcode;
    logic [15:0] in_term1;
    logic [15:0] in_term2;
    logic        alu_enable;
    logic [5:0]  alu_opcode;
    logic [15:0] alu_term1;
    logic [15:0] alu_term2;
    logic [15:0] alu_result;
    logic        alu_fl_zero;
    logic        alu_fl_negative;
    logic        alu_fl_carry;
    logic        alu_fl_overflow;
    logic        alu_done;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_wb;
    logic        out_error;
    logic [3:0]  flags;

    int errors = 0;
    int checks = 0;
    int done_at = 1;
    int busy_cnt;
    int en_count;
    int lat;
    int en_before;

    alu_dispatch #(
        .DATA_W  (16),
        .OP_W    (6),
        .TIMEOUT (15)
    ) dut (
        .clk             (clk),
        .rst_b           (rst_b),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_opcode       (in_opcode),
        .in_term1        (in_term1),
        .in_term2        (in_term2),
        .alu_enable      (alu_enable),
        .alu_opcode      (alu_opcode),
        .alu_term1       (alu_term1),
        .alu_term2       (alu_term2),
        .alu_result      (alu_result),
        .alu_fl_zero     (alu_fl_zero),
        .alu_fl_negative (alu_fl_negative),
        .alu_fl_carry    (alu_fl_carry),
        .alu_fl_overflow (alu_fl_overflow),
        .alu_done        (alu_done),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_result      (out_result),
        .out_wb          (out_wb),
        .out_error       (out_error),
        .flags           (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: ADD, SUB and CMP (carry means no borrow on subtract)
    logic [16:0] s17;
    always_comb begin
        s17             = 17'd0;
        alu_result      = 16'd0;
        alu_fl_carry    = 1'b0;
        alu_fl_overflow = 1'b0;
        case (alu_opcode)
            6'h00: begin
                s17             = {1'b0, alu_term1} + {1'b0, alu_term2};
                alu_result      = s17[15:0];
                alu_fl_carry    = s17[16];
                alu_fl_overflow = (alu_term1[15] == alu_term2[15]) && (s17[15] != alu_term1[15]);
            end
            6'h01, 6'h09: begin
                s17             = {1'b0, alu_term1} - {1'b0, alu_term2};
                alu_result      = s17[15:0];
                alu_fl_carry    = ~s17[16];
                alu_fl_overflow = (alu_term1[15] != alu_term2[15]) && (s17[15] != alu_term1[15]);
            end
            default: begin
                alu_result = 16'd0;
            end
        endcase
        alu_fl_zero     = (alu_result == 16'd0);
        alu_fl_negative = alu_result[15];
    end

    assign alu_done = alu_enable && (done_at != 0) && ((busy_cnt + 1) == done_at);

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            busy_cnt <= 0;
        end else if (alu_enable) begin
            busy_cnt <= busy_cnt + 1;
            en_count <= en_count + 1;
        end else begin
            busy_cnt <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one op at edge N; lat = edges from N until out_valid is seen
    task automatic issue(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
        in_valid  = 1'b1;
        in_opcode = op;
        in_term1  = a;
        in_term2  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            errors++;
            checks++;
            $display("FAIL resp_timeout: got no out_valid expected out_valid within 200 cycles");
        end
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
        check("back_idle", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation hang expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        en_count  = 0;
        rst_b     = 1'b0;
        in_valid  = 1'b0;
        in_opcode = 6'd0;
        in_term1  = 16'd0;
        in_term2  = 16'd0;
        out_ready = 1'b1;
        #12;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),   32'd1);
        check("rst_out_valid", 32'(out_valid),  32'd0);
        check("rst_alu_en",    32'(alu_enable), 32'd0);
        check("rst_flags",     32'(flags),      32'd0);
        check("rst_result",    32'(out_result), 32'd0);
        check("rst_err_wb",    32'({out_error, out_wb}), 32'd0);
        check("rst_operands",  32'({alu_opcode, alu_term1}), 32'd0);

        // ADD 5+10, immediate done
        done_at = 1;
        issue(6'h00, 16'd5, 16'd10);
        check("add_lat",    32'(lat),        32'd2);
        check("add_result", 32'(out_result), 32'd15);
        check("add_wb",     32'(out_wb),     32'd1);
        check("add_err",    32'(out_error),  32'd0);
        check("add_flags",  32'(flags),      32'h0);
        drain();

        // CMP 0x30 vs 0x20: no write-back, flags C=1
        issue(6'h09, 16'h0030, 16'h0020);
        check("cmp_wb",    32'(out_wb),    32'd0);
        check("cmp_err",   32'(out_error), 32'd0);
        check("cmp_flags", 32'(flags),     32'h4);
        drain();

        // SUB 16-16 sets Z
        issue(6'h01, 16'd16, 16'd16);
        check("sub_result", 32'(out_result), 32'd0);
        check("sub_wb",     32'(out_wb),     32'd1);
        check("sub_flags",  32'(flags),      32'h5);
        drain();

        // Illegal opcode 0x0C
        en_before = en_count;
        issue(6'h0C, 16'd1, 16'd2);
        check("ill_lat",    32'(lat),        32'd1);
        check("ill_err",    32'(out_error),  32'd1);
        check("ill_result", 32'(out_result), 32'd0);
        check("ill_wb",     32'(out_wb),     32'd0);
        check("ill_flags",  32'(flags),      32'h5);
        drain();
        check("ill_no_en",  32'(en_count),   32'(en_before));

        // DIV 30/0
        issue(6'h03, 16'd30, 16'd0);
        check("div0_lat",    32'(lat),        32'd1);
        check("div0_err",    32'(out_error),  32'd1);
        check("div0_result", 32'(out_result), 32'd0);
        check("div0_flags",  32'(flags),      32'h5);
        drain();
        check("div0_no_en",  32'(en_count),   32'(en_before));

        // Timeout: done withheld
        done_at = 0;
        issue(6'h00, 16'd1, 16'd1);
        check("to_lat",    32'(lat),        32'd16);
        check("to_err",    32'(out_error),  32'd1);
        check("to_result", 32'(out_result), 32'd0);
        check("to_wb",     32'(out_wb),     32'd0);
        check("to_flags",  32'(flags),      32'h5);
        check("to_en_off", 32'(alu_enable), 32'd0);
        drain();

        // done in the 15th BUSY cycle wins over the timeout
        done_at = 15;
        issue(6'h00, 16'h7FFF, 16'h0001);
        check("d15_lat",    32'(lat),        32'd16);
        check("d15_err",    32'(out_error),  32'd0);
        check("d15_result", 32'(out_result), 32'h8000);
        check("d15_flags",  32'(flags),      32'hA);
        drain();

        // Downstream stall for 5 cycles with a second op pending
        done_at   = 1;
        out_ready = 1'b0;
        issue(6'h00, 16'h0100, 16'h0023);
        in_valid  = 1'b1;
        in_opcode = 6'h01;
        in_term1  = 16'd9;
        in_term2  = 16'd4;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid",  32'(out_valid),  32'd1);
            check("stall_result", 32'(out_result), 32'h0123);
            check("stall_ready",  32'(in_ready),   32'd0);
            check("stall_opcode", 32'(alu_opcode), 32'h00);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_idle",   32'(in_ready),   32'd1);
        check("stall_no_acc", 32'(alu_enable), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("stall_acc_en", 32'(alu_enable), 32'd1);
        check("stall_acc_op", 32'(alu_opcode), 32'h01);
        @(posedge clk);
        #1;
        check("stall2_result", 32'(out_result), 32'd5);
        drain();

        // Asynchronous reset during BUSY
        done_at = 0;
        in_valid  = 1'b1;
        in_opcode = 6'h00;
        in_term1  = 16'd7;
        in_term2  = 16'd8;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_en", 32'(alu_enable), 32'd1);
        #1;
        rst_b = 1'b0;
        #1;
        check("async_en",    32'(alu_enable), 32'd0);
        check("async_valid", 32'(out_valid),  32'd0);
        #1;
        rst_b = 1'b1;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);
        check("post_rst_flags", 32'(flags),    32'd0);
        @(posedge clk);
        #1;
        done_at = 1;
        issue(6'h00, 16'd1, 16'd2);
        check("post_rst_lat",    32'(lat),        32'd2);
        check("post_rst_result", 32'(out_result), 32'd3);
        check("post_rst_err",    32'(out_error),  32'd0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
